// File: rtl/rgb_pkg.sv
// Shared types and phase encodings for the RGB encoder sequencer.
package rgb_pkg;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } chan_e;

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    PH2,
    PH3,
    PH4
  } seq_state_e;

  // {A,B} per phase, index 0 = PH1 ... 3 = PH4
  localparam logic [1:0] UP_AB   [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [1:0] DOWN_AB [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  // Quadrature output for a given phase and direction; IDLE drives 00.
  function automatic logic [1:0] phase_ab(input seq_state_e s, input logic up);
    logic [1:0] ab;
    ab = 2'b00;
    case (s)
      PH1:     ab = up ? UP_AB[0] : DOWN_AB[0];
      PH2:     ab = up ? UP_AB[1] : DOWN_AB[1];
      PH3:     ab = up ? UP_AB[2] : DOWN_AB[2];
      PH4:     ab = up ? UP_AB[3] : DOWN_AB[3];
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  // Round-robin successor: red -> green -> blue -> red.
  function automatic chan_e next_chan(input chan_e c);
    chan_e n;
    case (c)
      RED:     n = GREEN;
      GREEN:   n = BLUE;
      default: n = RED;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_step_gen.sv
// Single-detent quadrature step generator: walks PH1..PH4, each phase held
// PHASE_CYCLES clocks. a/b give the encoding of the phase entered on the next
// edge so the owner can register them per channel without extra latency.
module quad_step_gen
  import rgb_pkg::*;
#(
  parameter int PHASE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic dir,
  output logic a,
  output logic b,
  output logic done,
  output logic busy
);

  localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(PHASE_CYCLES - 1);

  seq_state_e    state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          up_reg, up_next;
  logic          phase_last;

  // State, phase timer and latched direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      up_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      up_reg    <= up_next;
    end
  end

  // Phase sequencing; PH4 exit either chains straight into a new detent or idles
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    up_next    = up_reg;
    done       = 1'b0;
    phase_last = (timer_reg == LAST);
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = PH1;
          up_next    = dir;
        end
      end
      PH1, PH2, PH3: begin
        if (phase_last) begin
          timer_next = '0;
          state_next = (state_reg == PH1) ? PH2 : (state_reg == PH2) ? PH3 : PH4;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      PH4: begin
        if (phase_last) begin
          done       = 1'b1;
          timer_next = '0;
          if (start) begin
            state_next = PH1;
            up_next    = dir;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
    {a, b} = phase_ab(state_next, up_next);
    busy   = (state_reg != IDLE);
  end

endmodule

// File: rtl/rgb_encoder_sequencer.sv
// RGB encoder sequencer: holds per-channel targets and tracked levels,
// arbitrates one shared step generator round-robin and demuxes its
// quadrature output onto the granted channel's registered A/B pins.
module rgb_encoder_sequencer
  import rgb_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MAX_LEVEL    = 255,
  parameter int PHASE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [1:0]       tgt_chan,
  input  logic [WIDTH-1:0] tgt_level,
  output logic             red_A,
  output logic             red_B,
  output logic             green_A,
  output logic             green_B,
  output logic             blue_A,
  output logic             blue_B,
  output logic [WIDTH-1:0] cur_red,
  output logic [WIDTH-1:0] cur_green,
  output logic [WIDTH-1:0] cur_blue,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_LEVEL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] tgt_reg [3];
  logic [WIDTH-1:0] tgt_next[3];
  logic [WIDTH-1:0] cur_reg [3];
  logic [WIDTH-1:0] cur_next[3];
  logic [WIDTH-1:0] eval_tgt[3];
  logic [WIDTH-1:0] eval_cur[3];
  logic [1:0]       ab_reg  [3];
  logic [1:0]       ab_next [3];
  logic [2:0]       pending;

  chan_e            grant_reg, rr_reg, eval_rr, pick, scan, grant_sel;
  logic             up_reg, pick_up, found, start, ready_reg;
  logic             wr_en;
  logic [WIDTH-1:0] wr_level;
  logic             gen_a, gen_b, gen_done, gen_busy;

  assign wr_en    = tgt_valid && ready_reg && (tgt_chan != 2'd3);
  assign wr_level = (tgt_level > MAX_L) ? MAX_L : tgt_level;

  // When a detent finishes this cycle, arbitration looks at the post-edge
  // view (new target, stepped level); otherwise at the current registers.
  assign eval_rr = gen_done ? next_chan(grant_reg) : rr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign tgt_next[gi] = (wr_en && tgt_chan == 2'(gi)) ? wr_level : tgt_reg[gi];
      assign cur_next[gi] = (gen_done && grant_reg == 2'(gi))
                          ? (up_reg ? cur_reg[gi] + ONE : cur_reg[gi] - ONE)
                          : cur_reg[gi];
      assign eval_tgt[gi] = gen_done ? tgt_next[gi] : tgt_reg[gi];
      assign eval_cur[gi] = gen_done ? cur_next[gi] : cur_reg[gi];
      assign pending[gi]  = (eval_cur[gi] != eval_tgt[gi]);
      assign ab_next[gi]  = (grant_sel == 2'(gi)) ? {gen_a, gen_b} : 2'b00;
    end
  endgenerate

  // Round-robin pick of the first pending channel at or after the pointer
  always_comb begin
    pick  = eval_rr;
    scan  = eval_rr;
    found = 1'b0;
    for (int off = 0; off < 3; off++) begin
      if (!found && pending[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
      scan = next_chan(scan);
    end
    pick_up   = (eval_tgt[pick] > eval_cur[pick]);
    start     = (!gen_busy || gen_done) && found;
    grant_sel = start ? pick : grant_reg;
  end

  quad_step_gen #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_step (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .dir  (pick_up),
    .a    (gen_a),
    .b    (gen_b),
    .done (gen_done),
    .busy (gen_busy)
  );

  // Targets, levels, grant bookkeeping and registered A/B outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        tgt_reg[i] <= '0;
        cur_reg[i] <= '0;
        ab_reg[i]  <= 2'b00;
      end
      grant_reg <= RED;
      rr_reg    <= RED;
      up_reg    <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        tgt_reg[i] <= tgt_next[i];
        cur_reg[i] <= cur_next[i];
        ab_reg[i]  <= ab_next[i];
      end
      ready_reg <= 1'b1;
      if (start) begin
        grant_reg <= pick;
        up_reg    <= pick_up;
      end
      if (gen_done) begin
        rr_reg <= next_chan(grant_reg);
      end
    end
  end

  assign tgt_ready = ready_reg;
  assign {red_A, red_B}     = ab_reg[0];
  assign {green_A, green_B} = ab_reg[1];
  assign {blue_A, blue_B}   = ab_reg[2];
  assign cur_red   = cur_reg[0];
  assign cur_green = cur_reg[1];
  assign cur_blue  = cur_reg[2];
  assign busy      = gen_busy;

endmodule

// File: doc/rgb_encoder_sequencer.md
Name: rgb_encoder_sequencer

Overview:
- Programmatic front end for the RGB LED driver. Accepts per-channel target brightness levels from a host or FSM.
- Tracks each channel's current level and emits the quadrature detent sequences on red/green/blue A/B that move the driver's level toward each target.
- One shared step generator serves all three channels, arbitrated round-robin, one detent per grant.

Parameters:
- WIDTH, 8, level width in bits.
- MAX_LEVEL, 255, upper clamp for targets; must be ≤ 2^WIDTH-1.
- PHASE_CYCLES, 1, clock cycles each quadrature phase is held; must be ≥ 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tgt_valid  in  1  target write strobe
- tgt_ready  out  1  constant 1 out of reset; 0 while rst_n low
- tgt_chan  in  2  0=red, 1=green, 2=blue, 3=ignored
- tgt_level  in  WIDTH  requested level
- red_A, red_B, green_A, green_B, blue_A, blue_B  out  1 each  quadrature outputs to driver
- cur_red, cur_green, cur_blue  out  WIDTH each  tracked level per channel
- busy  out  1  high when FSM is not IDLE

Behaviour:
- Reset (async, rst_n low):
  - All A/B outputs 0, cur_* 0, targets 0, FSM IDLE, rr pointer at red, busy 0.
  - The driver must be reset by the same event so tracked and actual levels agree.
- Target write: on a clk edge with tgt_valid=1 and tgt_chan<3, tgt[chan] <= min(tgt_level, MAX_LEVEL). tgt_chan=3 is a no-op. A new target overwrites the old one; there is no queue.
- A channel is pending when cur != tgt. Direction is up if tgt > cur, down otherwise.
- FSM states: IDLE, PH1, PH2, PH3, PH4. Each PHx is held PHASE_CYCLES cycles via a phase timer.
- IDLE:
  - If any channel is pending, grant the first pending channel at or after the rr pointer (order red→green→blue→red), latch the direction, then go to PH1.
  - Otherwise stay in IDLE.
- Up encoding (granted channel, A,B): PH1=10, PH2=11, PH3=01, PH4=00.
- Down encoding: PH1=01, PH2=11, PH3=10, PH4=00.
- Non-granted channel outputs are 00 at all times. All A/B outputs are registered.
- On PH4 exit:
  - cur[grant] ±1.
  - rr pointer = grant+1 (mod 3).
  - Re-arbitrate immediately: go to PH1 for the next pending channel, or IDLE if none. No idle gap is inserted between back-to-back detents.
- Latency (PHASE_CYCLES=1):
  - Write sampled at edge k; FSM leaves IDLE at edge k+1 (first A or B change visible after edge k+1).
  - One detent = 4·PHASE_CYCLES cycles.
- A target change mid-detent never aborts the in-flight detent. Direction is re-evaluated only at the next grant.
- A write to the currently granted channel takes effect after the current detent.
- No wrap: cur moves only toward tgt, and tgt ≤ MAX_LEVEL, so cur stays in [0, MAX_LEVEL].
- A write and a PH4 completion on the same channel in the same cycle:
  - The cur update uses the old direction.
  - The pending check for the next grant uses the new tgt and the updated cur.
- Async reset mid-detent forces all outputs to 0 without a clock edge. Operation resumes from IDLE after rst_n deasserts.

Decomposition:
- Package rgb_pkg holds:
  - chan_e enum: RED=0, GREEN=1, BLUE=2.
  - seq_state_e enum: IDLE, PH1..PH4.
  - Localparam arrays UP_AB and DOWN_AB giving the 2-bit phase encodings.
- Sub-module quad_step_gen owns the phase timer and PH1..PH4 sequencing. It takes start and dir, outputs A, B and a done pulse. The top level owns the targets, levels, arbiter and output demux.

Test Plan:
- Reset: hold rst_n low with random inputs → all A/B 0, cur_* 0, busy 0, tgt_ready 0. After release, tgt_ready 1 and busy stays 0.
- Red up, PHASE_CYCLES=1: write red=3 → red_A/B shows 10,11,01,00 ×3 over 12 cycles; green/blue stay 00; cur_red=3; busy falls after edge k+13.
- Down: from red=64 write red=44 → 20 detents of 01,11,10,00; cur_red=44.
- Arbitration: write red=2, green=2, blue=2 on consecutive cycles → grants R,G,B,R,G,B; 24 cycles of activity; all cur_* end at 2.
- Overwrite and clamp:
  - Write red=5, then red=0 while detent 2 is in flight → detent 2 completes (cur_red=2), then 2 down detents; final 0.
  - Write blue=300 with WIDTH=9, MAX_LEVEL=255 → cur_blue stops at 255.
  - tgt_chan=3 changes nothing.
- Async reset asserted during PH2 of a green detent → green_A/B drop to 0 before the next clk edge; cur_* become 0; no further toggles until a new write.
